gray_seq_ctrl: RTL and testbench
================================

Name: gray_seq_ctrl

Overview:
- Synchronous controller that sequences an N-bit Gray-code counter at a programmable rate.
- Replaces the free-running ripple clock divider with a single-clock prescaler that generates a tick enable.
- Supports run/stop, a programmed step count with a done pulse, and single-step requests.
- Sits between the top-level control inputs and the Gray output, and drives both binary and Gray count values.

Parameters:
- WIDTH, 2, counter/Gray width in bits.
- DIV_W, 20, prescaler width in bits.
- CNT_W, 8, step-length counter width in bits.

Ports:
- clk  in  1  system clock, rising edge.
- res  in  1  reset, asynchronous, active-low (0 = reset).
- start  in  1  level-sampled; begins a run from IDLE.
- stop  in  1  aborts a run; returns to IDLE.
- step  in  1  single advance request from IDLE.
- div  in  DIV_W  tick period minus 1; latched at start.
- len  in  CNT_W  number of advances per run, 0 = free-run; latched at start.
- dir  in  1  0 = count up, 1 = count down (see Optional Feature).
- bin  out  WIDTH  binary count, registered.
- gray  out  WIDTH  Gray code of bin, registered, always equal to bin ^ (bin >> 1).
- tick  out  1  one-cycle strobe; high in the cycle where bin/gray first show a new value.
- busy  out  1  high in RUN and STEP states.
- done  out  1  one-cycle pulse when a finite-length run completes.

Behaviour:
- Reset (res=0, asynchronous): state=IDLE; bin=0, gray=0, tick=0, busy=0, done=0; prescaler, step counter and latched div/len are cleared. Reset asserted mid-run aborts the run immediately; there is no done pulse.
- FSM states: IDLE, RUN, STEP.
- IDLE:
  - start=1 -> RUN. Latch div_l=div and len_l=len; clear prescaler and step counter; set busy=1. bin keeps its value.
  - step=1 with start=0 -> STEP. start has priority over step.
- RUN:
  - Prescaler increments each cycle.
  - At the edge where prescaler==div_l: prescaler->0, bin advances by one modulo 2^WIDTH (wrap 3->0 for WIDTH=2), step counter increments, tick=1 for the next cycle.
  - First advance occurs div_l+1 cycles after the start edge. div_l=0 advances every cycle.
  - If len_l!=0 and the advance makes step counter==len_l: go to IDLE, done=1 and busy=0 in the same cycle as the final tick.
  - If len_l==0: run until stop. The step counter wraps silently.
  - stop=1: go to IDLE on that edge and set busy=0. stop has priority over a coincident advance, so there is no tick and bin holds.
  - start/step while in RUN are ignored. div/len changes take effect only at the next start.
- STEP: exactly one cycle. Advance bin by one, tick=1 for the next cycle, return to IDLE. busy=1 during STEP. stop is ignored in STEP.
- gray is updated on the same edge as bin, so the two are never inconsistent.
- tick and done are single-cycle pulses and are never asserted for two consecutive cycles. The exception is div_l=0, where tick stays high on every advance.

Optional Feature:
- Macro GRAY_SEQ_CTRL_DIR_EN.
- Defined: dir=1 makes every advance decrement bin modulo 2^WIDTH (0->3 for WIDTH=2). dir is sampled on each advance edge.
- Undefined: dir is ignored and always counts up. The port remains present.

Test Plan:
- Reset mid-run: div=3, start, wait 6 cycles, pull res low asynchronously -> bin=0, gray=0, busy=0, done=0 immediately; no done pulse after release.
- Finite run: from bin=0, div=3, len=4, pulse start -> tick every 4 cycles; gray sequence 01,11,10,00 with bin 1,2,3,0; done=1 together with the 4th tick; busy=0 from that cycle.
- Free run with stop: div=1, len=0, start; assert stop in the cycle after the 2nd tick -> bin=2, gray=11 held, busy=0 on the next edge, no further ticks.
- Single step: from bin=0 in IDLE, three 1-cycle step pulses 4 cycles apart -> gray 01, 11, 10; each tick 1 cycle wide; busy high for exactly 1 cycle per step.
- Priority: start and step together in IDLE -> RUN entered, no immediate advance. start pulsed again during RUN -> ignored, prescaler and step counter are not reset.
- GRAY_SEQ_CTRL_DIR_EN defined, dir=1, bin=0, one step -> bin=3, gray=10. With the macro undefined, the same stimulus gives bin=1, gray=01.

Source files
------------

// File: rtl/gray_seq_ctrl.sv
// gray_seq_ctrl: single-clock prescaled Gray-code sequencer with
// run/stop, finite-length runs with done pulse, and single steps.
//
// Ports:
//   clk   system clock, rising edge
//   res   asynchronous active-low reset
//   start begin a run from IDLE (latches div/len)
//   stop  abort a run, back to IDLE
//   step  single advance request from IDLE
//   div   tick period minus 1
//   len   advances per run, 0 = free-run
//   dir   0 = up, 1 = down (only with GRAY_SEQ_CTRL_DIR_EN)
//   bin   registered binary count
//   gray  registered Gray code of bin
//   tick  strobe in the cycle a new count appears
//   busy  high in RUN and STEP
//   done  pulse when a finite-length run completes
//
// Optional feature macro: GRAY_SEQ_CTRL_DIR_EN (down counting).

module gray_seq_ctrl #(
  parameter int WIDTH = 2,
  parameter int DIV_W = 20,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             res,
  input  logic             start,
  input  logic             stop,
  input  logic             step,
  input  logic [DIV_W-1:0] div,
  input  logic [CNT_W-1:0] len,
  input  logic             dir,
  output logic [WIDTH-1:0] bin,
  output logic [WIDTH-1:0] gray,
  output logic             tick,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    STEP = 2'd2
  } state_e;

  state_e           state_q;
  logic [DIV_W-1:0] presc_q;
  logic [CNT_W-1:0] cnt_q;
  logic [DIV_W-1:0] div_q;
  logic [CNT_W-1:0] len_q;

  logic [WIDTH-1:0] bin_d;
  logic [WIDTH-1:0] gray_d;
  logic [CNT_W-1:0] cnt_d;
  logic             presc_hit;
  logic             last_adv;

`ifdef GRAY_SEQ_CTRL_DIR_EN
  always_comb begin
    bin_d = bin + WIDTH'(1);
    if (dir) begin
      bin_d = bin - WIDTH'(1);
    end
  end
`else
  logic unused_dir;
  assign unused_dir = dir;

  always_comb begin
    bin_d = bin + WIDTH'(1);
  end
`endif

  // Gray value is derived from the next binary value so both
  // registers load on the same edge and never disagree.
  assign gray_d    = bin_d ^ (bin_d >> 1);
  assign cnt_d     = cnt_q + CNT_W'(1);
  assign presc_hit = (presc_q == div_q);
  assign last_adv  = (len_q != '0) && (cnt_d == len_q);

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      state_q <= IDLE;
      presc_q <= '0;
      cnt_q   <= '0;
      div_q   <= '0;
      len_q   <= '0;
      bin     <= '0;
      gray    <= '0;
      tick    <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      tick <= 1'b0;
      done <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (start) begin
            state_q <= RUN;
            div_q   <= div;
            len_q   <= len;
            presc_q <= '0;
            cnt_q   <= '0;
            busy    <= 1'b1;
          end else if (step) begin
            state_q <= STEP;
            busy    <= 1'b1;
          end
        end
        RUN: begin
          // stop wins over a coincident advance
          if (stop) begin
            state_q <= IDLE;
            busy    <= 1'b0;
          end else if (presc_hit) begin
            presc_q <= '0;
            cnt_q   <= cnt_d;
            bin     <= bin_d;
            gray    <= gray_d;
            tick    <= 1'b1;
            if (last_adv) begin
              state_q <= IDLE;
              busy    <= 1'b0;
              done    <= 1'b1;
            end
          end else begin
            presc_q <= presc_q + DIV_W'(1);
          end
        end
        STEP: begin
          bin     <= bin_d;
          gray    <= gray_d;
          tick    <= 1'b1;
          busy    <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gray_seq_ctrl.sv
// tb_gray_seq_ctrl: scoreboard bench for gray_seq_ctrl.
// Expected per-cycle outputs are queued with stimulus, checked after the edge.

module tb_gray_seq_ctrl;

  logic        clk   = 1'b0;
  logic        res   = 1'b0;
  logic        start = 1'b0;
  logic        stop  = 1'b0;
  logic        step  = 1'b0;
  logic        dir   = 1'b0;
  logic [19:0] div   = '0;
  logic [7:0]  len   = '0;
  logic [1:0]  bin;
  logic [1:0]  gray;
  logic        tick;
  logic        busy;
  logic        done;

  gray_seq_ctrl #(
    .WIDTH(2),
    .DIV_W(20),
    .CNT_W(8)
  ) dut (
    .clk  (clk),
    .res  (res),
    .start(start),
    .stop (stop),
    .step (step),
    .div  (div),
    .len  (len),
    .dir  (dir),
    .bin  (bin),
    .gray (gray),
    .tick (tick),
    .busy (busy),
    .done (done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0] b;
    logic [1:0] g;
    logic       t;
    logic       bz;
    logic       d;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;
  logic [1:0] gtab [4] = '{2'b00, 2'b01, 2'b11, 2'b10};

`ifdef GRAY_SEQ_CTRL_DIR_EN
  localparam int DN_BIN = 3;
`else
  localparam int DN_BIN = 1;
`endif

  task automatic chk(input string tag,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d t=%0t",
               tag, act, exp, $time);
    end
  endtask

  function automatic exp_t mk(input int b, input bit t,
                              input bit bz, input bit d);
    exp_t e;
    int   bm;
    bm   = b & 3;
    e.b  = bm[1:0];
    e.g  = gtab[bm];
    e.t  = t;
    e.bz = bz;
    e.d  = d;
    return e;
  endfunction

  task automatic cmp(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      chk({tag, "_sb_empty"}, 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      chk({tag, "_bin"},  32'(bin),  32'(e.b));
      chk({tag, "_gray"}, 32'(gray), 32'(e.g));
      chk({tag, "_tick"}, 32'(tick), 32'(e.t));
      chk({tag, "_busy"}, 32'(busy), 32'(e.bz));
      chk({tag, "_done"}, 32'(done), 32'(e.d));
    end
  endtask

  task automatic cyc(input string tag, input exp_t e);
    sb.push_back(e);
    @(posedge clk);
    #1;
    cmp(tag);
  endtask

  task automatic now(input string tag, input exp_t e);
    sb.push_back(e);
    cmp(tag);
  endtask

  task automatic do_reset();
    res = 1'b0;
    #1;
    now("rst", mk(0, 0, 0, 0));
    @(posedge clk);
    #1;
    res = 1'b1;
  endtask

  initial begin
    #2;
    now("por", mk(0, 0, 0, 0));
    @(posedge clk);
    #1;
    res = 1'b1;
    cyc("idle", mk(0, 0, 0, 0));

    // finite run: div=3 len=4, done with 4th tick
    div = 20'd3; len = 8'd4; start = 1'b1;
    cyc("fin_go", mk(0, 0, 1, 0));
    start = 1'b0;
    for (int k = 1; k <= 16; k++)
      cyc("fin", mk(k / 4, (k % 4) == 0, k < 16, k == 16));
    cyc("fin_end", mk(0, 0, 0, 0));
    cyc("fin_end", mk(0, 0, 0, 0));

    // free run with stop colliding with an advance edge
    div = 20'd1; len = 8'd0; start = 1'b1;
    cyc("free_go", mk(0, 0, 1, 0));
    start = 1'b0;
    for (int k = 1; k <= 5; k++)
      cyc("free", mk(k / 2, (k % 2) == 0, 1, 0));
    stop = 1'b1;
    cyc("stop", mk(2, 0, 0, 0));
    stop = 1'b0;
    for (int k = 0; k < 3; k++)
      cyc("stop_hold", mk(2, 0, 0, 0));

    // reset mid-run
    div = 20'd3; len = 8'd0; start = 1'b1;
    cyc("rm_go", mk(2, 0, 1, 0));
    start = 1'b0;
    for (int k = 1; k <= 6; k++)
      cyc("rm", mk(2 + k / 4, (k % 4) == 0, 1, 0));
    #2;
    res = 1'b0;
    #1;
    now("rm_async", mk(0, 0, 0, 0));
    cyc("rm_low", mk(0, 0, 0, 0));
    res = 1'b1;
    for (int k = 0; k < 6; k++)
      cyc("rm_after", mk(0, 0, 0, 0));

    // single steps, 4 cycles apart
    for (int p = 0; p < 3; p++) begin
      step = 1'b1;
      cyc("stp_busy", mk(p, 0, 1, 0));
      step = 1'b0;
      cyc("stp_tick", mk(p + 1, 1, 0, 0));
      cyc("stp_gap", mk(p + 1, 0, 0, 0));
      cyc("stp_gap", mk(p + 1, 0, 0, 0));
    end

    // start+step together, then start ignored in RUN
    div = 20'd2; len = 8'd2; start = 1'b1; step = 1'b1;
    cyc("pri_go", mk(3, 0, 1, 0));
    start = 1'b0; step = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      start = (k == 2);
      cyc("pri", mk(3 + k / 3, (k % 3) == 0, k < 6, k == 6));
    end
    start = 1'b0;
    cyc("pri_end", mk(1, 0, 0, 0));

    // direction on a single step from 0
    do_reset();
    dir = 1'b1; step = 1'b1;
    cyc("dir_go", mk(0, 0, 1, 0));
    step = 1'b0;
    cyc("dir_tick", mk(DN_BIN, 1, 0, 0));
    dir = 1'b0;
    cyc("dir_hold", mk(DN_BIN, 0, 0, 0));

    // div=0: tick every cycle, done on the last
    div = 20'd0; len = 8'd3; start = 1'b1;
    cyc("d0_go", mk(DN_BIN, 0, 1, 0));
    start = 1'b0;
    for (int k = 1; k <= 3; k++)
      cyc("d0", mk(DN_BIN + k, 1, k < 3, k == 3));
    cyc("d0_end", mk(DN_BIN + 3, 0, 0, 0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
